tlp_tx_framer: RTL and testbench

Transmit-side framer directly downstream of the TLP header-field stage. Accepts one decoded request header (fmt/type/TC/attr/length/requester ID/tag/byte enables/address) per handshake, checks tag width and payload length, packs it into 3 or 4 PCIe header DWs, and streams the header DWs followed by the payload DWs onto a 32-bit valid/ready link-side stream with SOP/EOP marking.

---
 rtl/tlp_pkg.sv | 57 +++++
 rtl/tlp_tx_framer_pack.sv | 46 ++++
 rtl/tlp_tx_framer.sv | 165 ++++++++++++++++
 tb/tb_tlp_tx_framer.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_pkg.sv
// Shared types and encodings for the TLP transmit framer:
// fmt bit meanings, header DW0 field positions, FSM states.
package tlp_pkg;

  localparam int CNT_W = 11;

  localparam int FMT_4DW_BIT  = 0;
  localparam int FMT_DATA_BIT = 1;

  localparam int DW0_FMT  = 29;
  localparam int DW0_TYPE = 24;
  localparam int DW0_T9   = 23;
  localparam int DW0_TC   = 20;
  localparam int DW0_T8   = 19;
  localparam int DW0_A2   = 18;
  localparam int DW0_LN   = 17;
  localparam int DW0_TH   = 16;
  localparam int DW0_TD   = 15;
  localparam int DW0_EP   = 14;
  localparam int DW0_ATTR = 12;
  localparam int DW0_AT   = 10;
  localparam int DW0_LEN  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } state_e;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic        th;
    logic        td;
    logic        ep;
    logic [1:0]  at;
    logic [9:0]  length;
    logic [15:0] req_id;
    logic [9:0]  tag;
    logic [3:0]  first_be;
    logic [3:0]  last_be;
    logic [63:0] addr;
  } hdr_t;

  // Length field 0 means 1024 DWs.
  function automatic logic [CNT_W-1:0] pay_dws(
    input logic [2:0] fmt,
    input logic [9:0] len
  );
    if (!fmt[FMT_DATA_BIT]) return '0;
    if (len == 10'd0) return CNT_W'(1024);
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/tlp_tx_framer_pack.sv
// Combinational packing of decoded header fields into
// the four candidate PCIe header DWs.
import tlp_pkg::*;

module tlp_tx_framer_pack #(
  parameter int SUPPORT_10BIT_TAG = 0
) (
  input  hdr_t             hdr,
  output logic [3:0][31:0] dw
);

  logic        t9;
  logic        t8;
  logic [31:0] dw0;
  logic [31:0] addr_lo;
  logic        unused_addr;

  assign unused_addr = ^hdr.addr[1:0];

  always_comb begin
    t9 = (SUPPORT_10BIT_TAG != 0) && hdr.tag[9];
    t8 = (SUPPORT_10BIT_TAG != 0) && hdr.tag[8];
    addr_lo = {hdr.addr[31:2], 2'b00};
    dw0 = '0;
    dw0[DW0_FMT +: 3]  = hdr.fmt;
    dw0[DW0_TYPE +: 5] = hdr.typ;
    dw0[DW0_T9]        = t9;
    dw0[DW0_TC +: 3]   = hdr.tc;
    dw0[DW0_T8]        = t8;
    dw0[DW0_A2]        = hdr.attr[2];
    dw0[DW0_LN]        = 1'b0;
    dw0[DW0_TH]        = hdr.th;
    dw0[DW0_TD]        = hdr.td;
    dw0[DW0_EP]        = hdr.ep;
    dw0[DW0_ATTR +: 2] = hdr.attr[1:0];
    dw0[DW0_AT +: 2]   = hdr.at;
    dw0[DW0_LEN +: 10] = hdr.length;
    dw[0] = dw0;
    dw[1] = {hdr.req_id, hdr.tag[7:0],
             hdr.last_be, hdr.first_be};
    dw[2] = hdr.fmt[FMT_4DW_BIT] ?
            hdr.addr[63:32] : addr_lo;
    dw[3] = addr_lo;
  end

endmodule

// File: rtl/tlp_tx_framer.sv
// TLP transmit framer: checks and registers one header,
// streams its header DWs then payload DWs with SOP/EOP.
import tlp_pkg::*;

module tlp_tx_framer #(
  parameter int SUPPORT_10BIT_TAG = 0,
  parameter int MAX_PAYLOAD_DW    = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [2:0]  hdr_fmt,
  input  logic [4:0]  hdr_type,
  input  logic [2:0]  hdr_tc,
  input  logic [2:0]  hdr_attr,
  input  logic        hdr_th,
  input  logic        hdr_td,
  input  logic        hdr_ep,
  input  logic [1:0]  hdr_at,
  input  logic [9:0]  hdr_length,
  input  logic [15:0] hdr_req_id,
  input  logic [9:0]  hdr_tag,
  input  logic [3:0]  hdr_first_be,
  input  logic [3:0]  hdr_last_be,
  input  logic [63:0] hdr_addr,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic [31:0] pl_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        err_tag,
  output logic        err_len
);

  localparam logic [CNT_W-1:0] MAX_DW =
    CNT_W'(MAX_PAYLOAD_DW);

  state_e           state_q, state_d;
  hdr_t             hdr_q, hdr_d, hdr_in;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, pay_in;
  logic             err_tag_q, err_tag_d;
  logic             err_len_q, err_len_d;
  logic             tag_bad, len_bad, hdr_last;
  logic [3:0][31:0] dw;

  tlp_tx_framer_pack #(
    .SUPPORT_10BIT_TAG(SUPPORT_10BIT_TAG)
  ) u_pack (
    .hdr(hdr_q),
    .dw (dw)
  );

  always_comb begin
    hdr_in.fmt      = hdr_fmt;
    hdr_in.typ      = hdr_type;
    hdr_in.tc       = hdr_tc;
    hdr_in.attr     = hdr_attr;
    hdr_in.th       = hdr_th;
    hdr_in.td       = hdr_td;
    hdr_in.ep       = hdr_ep;
    hdr_in.at       = hdr_at;
    hdr_in.length   = hdr_length;
    hdr_in.req_id   = hdr_req_id;
    hdr_in.tag      = hdr_tag;
    hdr_in.first_be = hdr_first_be;
    hdr_in.last_be  = hdr_last_be;
    hdr_in.addr     = hdr_addr;
    pay_in  = pay_dws(hdr_fmt, hdr_length);
    tag_bad = (SUPPORT_10BIT_TAG == 0) &&
              (hdr_tag[9:8] != 2'b00);
    len_bad = hdr_fmt[FMT_DATA_BIT] &&
              (pay_in > MAX_DW);
    hdr_last = idx_q ==
      (hdr_q.fmt[FMT_4DW_BIT] ? 2'd3 : 2'd2);
  end

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_tag_d = 1'b0;
    err_len_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hdr_valid) begin
          err_tag_d = tag_bad;
          err_len_d = len_bad;
          if (!tag_bad && !len_bad) begin
            state_d = ST_HDR;
            hdr_d   = hdr_in;
            idx_d   = 2'd0;
            cnt_d   = pay_in;
          end
        end
      end
      ST_HDR: begin
        if (tx_ready) begin
          idx_d = idx_q + 2'd1;
          if (hdr_last)
            state_d = (cnt_q != '0) ?
                      ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        if (pl_valid && tx_ready) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      hdr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_tag_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_tag_q <= err_tag_d;
      err_len_q <= err_len_d;
    end
  end

  always_comb begin
    hdr_ready = (state_q == ST_IDLE);
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    pl_ready  = 1'b0;
    unique case (1'b1)
      (state_q == ST_HDR): begin
        tx_valid = 1'b1;
        tx_data  = dw[idx_q];
        tx_sop   = (idx_q == 2'd0);
        tx_eop   = hdr_last && (cnt_q == '0);
      end
      (state_q == ST_DATA): begin
        tx_valid = pl_valid;
        pl_ready = tx_ready;
        tx_data  = pl_data;
        tx_eop   = pl_valid && (cnt_q == CNT_W'(1));
      end
      default: ;
    endcase
  end

  assign err_tag = err_tag_q;
  assign err_len = err_len_q;

endmodule

// File: tb/tb_tlp_tx_framer.sv
// Scoreboard bench for tlp_tx_framer: instance 0 rejects 10-bit
// tags, instance 1 accepts them; one instance is driven at a time.
module tb_tlp_tx_framer;

  localparam int MAXP = 128;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic        th;
    logic        td;
    logic        ep;
    logic [1:0]  at;
    logic [9:0]  len;
    logic [15:0] rid;
    logic [9:0]  tag;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [63:0] addr;
  } req_t;

  typedef struct packed {
    logic        is_pl;
    logic        sop;
    logic        eop;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  hdr_valid = '0;
  logic [1:0]  pl_valid = '0;
  logic [2:0]  hdr_fmt = '0;
  logic [4:0]  hdr_type = '0;
  logic [2:0]  hdr_tc = '0;
  logic [2:0]  hdr_attr = '0;
  logic        hdr_th = 1'b0;
  logic        hdr_td = 1'b0;
  logic        hdr_ep = 1'b0;
  logic [1:0]  hdr_at = '0;
  logic [9:0]  hdr_length = '0;
  logic [15:0] hdr_req_id = '0;
  logic [9:0]  hdr_tag = '0;
  logic [3:0]  hdr_first_be = '0;
  logic [3:0]  hdr_last_be = '0;
  logic [63:0] hdr_addr = '0;
  logic [31:0] pl_data = '0;
  logic        tx_ready = 1'b1;
  logic [1:0]  hdr_ready, pl_ready, tx_valid;
  logic [1:0]  tx_sop, tx_eop, err_tag, err_len;
  logic [31:0] tx_data [2];

  exp_t        expq[$];
  logic [1:0]  errq[$];
  logic [31:0] plq[$];
  logic [33:0] got[$];

  int checks = 0;
  int failures = 0;
  int act = 0;
  int rdy_pct = 100;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tlp_tx_framer #(
      .SUPPORT_10BIT_TAG(g),
      .MAX_PAYLOAD_DW(MAXP)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .hdr_valid   (hdr_valid[g]),
      .hdr_ready   (hdr_ready[g]),
      .hdr_fmt     (hdr_fmt),
      .hdr_type    (hdr_type),
      .hdr_tc      (hdr_tc),
      .hdr_attr    (hdr_attr),
      .hdr_th      (hdr_th),
      .hdr_td      (hdr_td),
      .hdr_ep      (hdr_ep),
      .hdr_at      (hdr_at),
      .hdr_length  (hdr_length),
      .hdr_req_id  (hdr_req_id),
      .hdr_tag     (hdr_tag),
      .hdr_first_be(hdr_first_be),
      .hdr_last_be (hdr_last_be),
      .hdr_addr    (hdr_addr),
      .pl_valid    (pl_valid[g]),
      .pl_ready    (pl_ready[g]),
      .pl_data     (pl_data),
      .tx_valid    (tx_valid[g]),
      .tx_ready    (tx_ready),
      .tx_data     (tx_data[g]),
      .tx_sop      (tx_sop[g]),
      .tx_eop      (tx_eop[g]),
      .err_tag     (err_tag[g]),
      .err_len     (err_len[g])
    );
  end

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic logic [33:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  // Payload source and sink-ready randomiser.
  initial begin : drv
    logic xfer;
    forever begin
      @(negedge clk);
      xfer = pl_valid[act] && pl_ready[act];
      @(posedge clk);
      #1;
      tx_ready = ($urandom_range(99, 0) < rdy_pct);
      if (xfer && plq.size() > 0) begin
        void'(plq.pop_front());
        pl_valid = '0;
      end
      if (pl_valid == '0 && plq.size() > 0 &&
          $urandom_range(3, 0) != 0) begin
        pl_valid[act] = 1'b1;
        pl_data = plq[0];
      end
    end
  end

  // Monitor: pops the scoreboard on every observed transfer.
  initial begin : mon
    int k, o;
    exp_t e;
    logic [1:0] ee;
    logic eh, stall;
    logic [33:0] prev;
    stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 1'b0;
      end else begin
        k = act;
        o = 1 - act;
        chk("other_quiet",
            64'({tx_valid[o], hdr_ready[o], pl_ready[o],
                 err_tag[o], err_len[o]}),
            64'(5'b01000));
        chk("hdr_ready", 64'(hdr_ready[k]),
            64'(expq.size() == 0));
        if (expq.size() == 0) begin
          chk("tx_valid_idle", 64'(tx_valid[k]), 64'(0));
          chk("pl_ready_idle", 64'(pl_ready[k]), 64'(0));
        end else if (expq[0].is_pl) begin
          chk("tx_valid_data", 64'(tx_valid[k]),
              64'(pl_valid[k]));
          chk("pl_ready_data", 64'(pl_ready[k]),
              64'(tx_ready));
        end else begin
          chk("tx_valid_hdr", 64'(tx_valid[k]), 64'(1));
          chk("pl_ready_hdr", 64'(pl_ready[k]), 64'(0));
        end
        if (stall)
          chk("stable",
              64'({tx_valid[k], tx_sop[k], tx_eop[k],
                   tx_data[k]}),
              64'({1'b1, prev}));
        stall = tx_valid[k] && !tx_ready;
        prev = {tx_sop[k], tx_eop[k], tx_data[k]};
        if (tx_valid[k] && tx_ready) begin
          if (expq.size() == 0) begin
            fail("unexpected_word");
          end else begin
            e = expq.pop_front();
            chk("tx_word", 64'(prev),
                64'({e.sop, e.eop, e.d}));
          end
          got.push_back(prev);
        end
        eh = errq.size() > 0;
        ee = eh ? errq.pop_front() : 2'b00;
        if (eh || err_tag[k] || err_len[k])
          chk("err_pulse", 64'({err_tag[k], err_len[k]}),
              64'(ee));
      end
    end
  end

  // Present one header and, once accepted, load the model.
  task automatic issue(input int k, input req_t r);
    logic [31:0] w [4];
    logic [31:0] d;
    int nh, pay, n;
    bit t10, tbad, lbad;
    logic t9, t8;
    t10 = (k == 1);
    act = k;
    got.delete();
    hdr_fmt = r.fmt;
    hdr_type = r.typ;
    hdr_tc = r.tc;
    hdr_attr = r.attr;
    hdr_th = r.th;
    hdr_td = r.td;
    hdr_ep = r.ep;
    hdr_at = r.at;
    hdr_length = r.len;
    hdr_req_id = r.rid;
    hdr_tag = r.tag;
    hdr_first_be = r.fbe;
    hdr_last_be = r.lbe;
    hdr_addr = r.addr;
    hdr_valid[k] = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (hdr_ready[k]) break;
    end
    @(posedge clk);
    #1;
    hdr_valid = '0;
    if (n == 100) begin
      fail("hdr_accept");
      return;
    end
    pay = r.fmt[1] ?
          ((r.len == 10'd0) ? 1024 : int'(r.len)) : 0;
    tbad = !t10 && (r.tag[9:8] != 2'b00);
    lbad = r.fmt[1] && (pay > MAXP);
    if (tbad || lbad) begin
      errq.push_back({tbad, lbad});
      return;
    end
    t9 = t10 ? r.tag[9] : 1'b0;
    t8 = t10 ? r.tag[8] : 1'b0;
    w[0] = (32'(r.fmt) << 29) | (32'(r.typ) << 24) |
           (32'(t9) << 23) | (32'(r.tc) << 20) |
           (32'(t8) << 19) | (32'(r.attr[2]) << 18) |
           (32'(r.th) << 16) | (32'(r.td) << 15) |
           (32'(r.ep) << 14) |
           (32'(r.attr[1:0]) << 12) |
           (32'(r.at) << 10) | 32'(r.len);
    w[1] = (32'(r.rid) << 16) | (32'(r.tag[7:0]) << 8) |
           (32'(r.lbe) << 4) | 32'(r.fbe);
    if (r.fmt[0]) begin
      nh = 4;
      w[2] = r.addr[63:32];
      w[3] = r.addr[31:0] & 32'hFFFF_FFFC;
    end else begin
      nh = 3;
      w[2] = r.addr[31:0] & 32'hFFFF_FFFC;
      w[3] = '0;
    end
    for (int i = 0; i < nh; i++)
      expq.push_back({1'b0, i == 0,
                      (i == nh - 1) && (pay == 0), w[i]});
    for (int i = 0; i < pay; i++) begin
      d = $urandom;
      plq.push_back(d);
      expq.push_back({1'b1, 1'b0, i == pay - 1, d});
    end
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 4000; n++) begin
      @(posedge clk);
      #2;
      if (expq.size() == 0 && errq.size() == 0 &&
          plq.size() == 0) break;
    end
    if (n == 4000) fail("drain");
  endtask

  function automatic req_t rand_req();
    req_t r;
    r = '0;
    r.fmt = 3'($urandom_range(7, 0));
    r.typ = 5'($urandom);
    r.tc = 3'($urandom);
    r.attr = 3'($urandom);
    r.th = 1'($urandom);
    r.td = 1'($urandom);
    r.ep = 1'($urandom);
    r.at = 2'($urandom);
    r.rid = 16'($urandom);
    r.fbe = 4'($urandom);
    r.lbe = 4'($urandom);
    r.addr = {$urandom, $urandom};
    r.tag = ($urandom_range(3, 0) == 0) ?
            10'($urandom) : {2'b00, 8'($urandom)};
    case ($urandom_range(9, 0))
      0: r.len = 10'd0;
      1: r.len = 10'($urandom_range(1023, 129));
      default: r.len = 10'($urandom_range(32, 1));
    endcase
    return r;
  endfunction

  initial begin : main
    req_t r;
    int n, nsop, neop;
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_hdr_ready", 64'(hdr_ready[k]), 64'(1));
      chk("rst_outs",
          64'({tx_valid[k], tx_sop[k], tx_eop[k],
               pl_ready[k], err_tag[k], err_len[k]}),
          64'(0));
      chk("rst_tx_data", 64'(tx_data[k]), 64'(0));
    end
    @(posedge clk);
    #3;
    rst = 1'b1;

    r = '0;
    r.len = 10'd1;
    r.tag = 10'h005;
    r.rid = 16'h0100;
    r.fbe = 4'hF;
    r.addr = 64'h1000;
    issue(0, r);
    drain();
    chk("mrd_n", 64'(got.size()), 64'(3));
    chk("mrd_dw0", 64'(got_at(0)), 64'({2'b10, 32'h00000001}));
    chk("mrd_dw1", 64'(got_at(1)), 64'({2'b00, 32'h0100050F}));
    chk("mrd_dw2", 64'(got_at(2)), 64'({2'b01, 32'h00001000}));

    r = '0;
    r.fmt = 3'b011;
    r.len = 10'd2;
    r.fbe = 4'hF;
    r.lbe = 4'hF;
    r.addr = 64'h1_0000_0040;
    issue(0, r);
    drain();
    chk("mwr_n", 64'(got.size()), 64'(6));
    chk("mwr_dw0", 64'(got_at(0)), 64'({2'b10, 32'h60000002}));
    chk("mwr_dw2", 64'(got_at(2)), 64'({2'b00, 32'h00000001}));
    chk("mwr_dw3", 64'(got_at(3)), 64'({2'b00, 32'h00000040}));
    chk("mwr_eop", 64'(got_at(5) >> 32), 64'(2'b01));

    r = '0;
    r.len = 10'd1;
    r.tag = 10'h105;
    issue(0, r);
    drain();
    chk("tag8_dropped", 64'(got.size()), 64'(0));
    issue(1, r);
    drain();
    chk("tag10_bit19", 64'(got_at(0) & 34'h0_0008_0000),
        64'(34'h0_0008_0000));
    chk("tag10_dw1_tag", 64'((got_at(1) >> 8) & 34'hFF),
        64'(8'h05));

    r = '0;
    r.fmt = 3'b010;
    r.len = 10'd0;
    issue(0, r);
    drain();
    chk("len1024_dropped", 64'(got.size()), 64'(0));
    r.len = 10'd128;
    issue(0, r);
    drain();
    chk("len128_n", 64'(got.size()), 64'(131));
    chk("len128_eop", 64'(got_at(130) >> 32), 64'(2'b01));

    rdy_pct = 50;
    r = rand_req();
    r.fmt = 3'b011;
    r.len = 10'd16;
    r.tag[9:8] = 2'b00;
    issue(0, r);
    drain();
    nsop = 0;
    neop = 0;
    foreach (got[i]) begin
      nsop += int'(got[i][33]);
      neop += int'(got[i][32]);
    end
    chk("bp_n", 64'(got.size()), 64'(20));
    chk("bp_sop", 64'(nsop), 64'(1));
    chk("bp_eop", 64'(neop), 64'(1));

    repeat (40) begin
      rdy_pct = $urandom_range(100, 30);
      issue(int'($urandom_range(1, 0)), rand_req());
      drain();
    end

    rdy_pct = 100;
    r = '0;
    r.fmt = 3'b011;
    r.len = 10'd8;
    r.addr = {$urandom, $urandom};
    issue(0, r);
    for (n = 0; n < 200; n++) begin
      @(posedge clk);
      if (got.size() >= 6) break;
    end
    if (n == 200) fail("rst_wait");
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_outs",
        64'({tx_valid[0], tx_sop[0], tx_eop[0], pl_ready[0]}),
        64'(0));
    chk("midrst_hdr_ready", 64'(hdr_ready[0]), 64'(1));
    expq.delete();
    plq.delete();
    errq.delete();
    pl_valid = '0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("post_rst_hdr_ready", 64'(hdr_ready[0]), 64'(1));
    r = '0;
    r.fmt = 3'b011;
    r.len = 10'd2;
    r.addr = 64'h1_0000_0040;
    issue(0, r);
    drain();
    chk("post_rst_n", 64'(got.size()), 64'(6));

    repeat (3) @(posedge clk);
    chk("end_expq", 64'(expq.size()), 64'(0));
    chk("end_errq", 64'(errq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
